// File: rtl/mcu_el2_pkg.sv
// Trace record types, serializer states and beat/header helpers shared by the trace buffer.
// MCU_EL2_TRACE_TIMESTAMP_EN adds a timestamp field to the record and a TS beat to the stream.
package mcu_el2_pkg;

    localparam logic [3:0] MCU_EL2_TRACE_MAGIC = 4'hA;

    typedef struct packed {
        logic [31:0] insn_ip;
        logic [31:0] address_ip;
        logic        valid_ip;
        logic        exception_ip;
        logic [4:0]  ecause_ip;
        logic        interrupt_ip;
        logic [31:0] tval_ip;
    } mcu_el2_trace_pkt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] insn;
        logic [31:0] tval;
        logic [4:0]  ecause;
        logic        exception;
        logic        interrupt;
        logic        has_tval;
        logic        ovf;
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } mcu_el2_trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_INSN,
        ST_TVAL,
        ST_TS
    } mcu_el2_trace_st_e;

    function automatic logic [2:0] rec_beats_m1(input mcu_el2_trace_rec_t r);
        logic [2:0] n;
        n = r.has_tval ? 3'd3 : 3'd2;
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
        n = n + 3'd1;
`endif
        return n;
    endfunction

    function automatic logic [31:0] rec_hdr(input mcu_el2_trace_rec_t r);
        logic [31:0] w;
        w        = '0;
        w[31:28] = MCU_EL2_TRACE_MAGIC;
        w[27]    = r.exception;
        w[26]    = r.interrupt;
        w[25:21] = r.ecause;
        w[20]    = r.has_tval;
        w[19]    = r.ovf;
        w[18:16] = rec_beats_m1(r);
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
        w[15:0]  = r.ts[15:0];
`endif
        return w;
    endfunction

    // State that follows st within one record; ST_IDLE means st was the final beat.
    function automatic mcu_el2_trace_st_e rec_next_st(input mcu_el2_trace_st_e st,
                                                      input mcu_el2_trace_rec_t r);
        mcu_el2_trace_st_e tail;
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
        tail = ST_TS;
`else
        tail = ST_IDLE;
`endif
        case (st)
            ST_HDR:  return ST_ADDR;
            ST_ADDR: return ST_INSN;
            ST_INSN: return r.has_tval ? ST_TVAL : tail;
            ST_TVAL: return tail;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] rec_word(input mcu_el2_trace_st_e st,
                                             input mcu_el2_trace_rec_t r);
        case (st)
            ST_HDR:  return rec_hdr(r);
            ST_ADDR: return r.addr;
            ST_INSN: return r.insn;
            ST_TVAL: return r.tval;
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
            ST_TS:   return r.ts;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic rec_last(input mcu_el2_trace_st_e st,
                                      input mcu_el2_trace_rec_t r);
        return (st != ST_IDLE) && (rec_next_st(st, r) == ST_IDLE);
    endfunction

endpackage

// File: rtl/mcu_el2_trace_fifo.sv
// Generic register FIFO; data written at an edge is visible at head the following cycle.
// No internal guard: the caller must never push when full unless popping in the same cycle.
module mcu_el2_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Entry behind the head lets the reader start the next record without a bubble.
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: rtl/mcu_el2_trace_buf.sv
// Retirement trace capture FIFO plus 32-bit record serializer; header one cycle after FIFO fill.
// Full FIFO drops and flags loss; outputs hold while stalled. Option: MCU_EL2_TRACE_TIMESTAMP_EN.
module mcu_el2_trace_buf
    import mcu_el2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en_i,
    input  logic [103:0]             trace_pkt_i,
    output logic [31:0]              tb_data_o,
    output logic                     tb_valid_o,
    output logic                     tb_last_o,
    input  logic                     tb_ready_i,
    output logic                     overflow_o,
    input  logic                     clr_i,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = $bits(mcu_el2_trace_rec_t);

    mcu_el2_trace_pkt_t pkt;
    mcu_el2_trace_rec_t rec_in;
    mcu_el2_trace_rec_t head_rec;
    mcu_el2_trace_rec_t next_rec;
    mcu_el2_trace_st_e  state;
    mcu_el2_trace_st_e  beat_st;
    logic               capture;
    logic               push;
    logic               pop;
    logic               drop;
    logic               pending_ovf;

    assign pkt     = trace_pkt_i;
    assign capture = trace_en_i & (pkt.valid_ip | pkt.exception_ip | pkt.interrupt_ip);
    assign pop     = tb_valid_o & tb_ready_i & tb_last_o;
    assign push    = capture & ((level_o < LW'(DEPTH)) | pop);
    assign drop    = capture & ~push;

`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        rec_in           = '0;
        rec_in.addr      = pkt.address_ip;
        rec_in.insn      = pkt.insn_ip;
        rec_in.tval      = pkt.tval_ip;
        rec_in.ecause    = pkt.ecause_ip;
        rec_in.exception = pkt.exception_ip;
        rec_in.interrupt = pkt.interrupt_ip;
        rec_in.has_tval  = pkt.exception_ip | pkt.interrupt_ip;
        rec_in.ovf       = pending_ovf;
`ifdef MCU_EL2_TRACE_TIMESTAMP_EN
        rec_in.ts        = cyc_cnt;
`endif
    end

    mcu_el2_trace_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rec_in),
        .pop       (pop),
        .head_data (head_rec),
        .next_data (next_rec),
        .level     (level_o)
    );

    // A clear in the same cycle as a drop leaves the counters at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o  <= '0;
            overflow_o  <= 1'b0;
            pending_ovf <= 1'b0;
        end else begin
            if (clr_i) begin
                drop_cnt_o <= '0;
                overflow_o <= 1'b0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != {CNT_W{1'b1}}) begin
                    drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                end
            end
            if (push) begin
                pending_ovf <= 1'b0;
            end else if (drop) begin
                pending_ovf <= 1'b1;
            end
        end
    end

    assign beat_st = rec_next_st(state, head_rec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tb_data_o  <= '0;
            tb_valid_o <= 1'b0;
            tb_last_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (level_o != '0) begin
                        state      <= ST_HDR;
                        tb_data_o  <= rec_hdr(head_rec);
                        tb_valid_o <= 1'b1;
                        tb_last_o  <= 1'b0;
                    end
                end
                default: begin
                    if (tb_valid_o && tb_ready_i) begin
                        if (tb_last_o) begin
                            if (level_o > LW'(1)) begin
                                state      <= ST_HDR;
                                tb_data_o  <= rec_hdr(next_rec);
                                tb_valid_o <= 1'b1;
                                tb_last_o  <= 1'b0;
                            end else begin
                                state      <= ST_IDLE;
                                tb_data_o  <= '0;
                                tb_valid_o <= 1'b0;
                                tb_last_o  <= 1'b0;
                            end
                        end else begin
                            state     <= beat_st;
                            tb_data_o <= rec_word(beat_st, head_rec);
                            tb_last_o <= rec_last(beat_st, head_rec);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_el2_trace_buf.sv
// Scoreboarded bench: stimulus queues expected stream words, a negedge monitor checks handshakes.
module tb_mcu_el2_trace_buf;
    import mcu_el2_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               trace_en;
    logic               tb_ready;
    logic               clr;
    mcu_el2_trace_pkt_t pkt;
    logic [103:0]       trace_pkt;

    logic [31:0] tb_data,  sat_data;
    logic        tb_valid, sat_valid;
    logic        tb_last,  sat_last;
    logic        overflow, sat_overflow;
    logic [15:0] drop_cnt;
    logic [1:0]  sat_drop_cnt;
    logic [2:0]  level,    sat_level;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign trace_pkt = pkt;

    always #5 clk = ~clk;

    mcu_el2_trace_buf #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .trace_en_i(trace_en), .trace_pkt_i(trace_pkt),
        .tb_data_o(tb_data), .tb_valid_o(tb_valid), .tb_last_o(tb_last),
        .tb_ready_i(tb_ready), .overflow_o(overflow), .clr_i(clr),
        .drop_cnt_o(drop_cnt), .level_o(level)
    );

    mcu_el2_trace_buf #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .trace_en_i(trace_en), .trace_pkt_i(trace_pkt),
        .tb_data_o(sat_data), .tb_valid_o(sat_valid), .tb_last_o(sat_last),
        .tb_ready_i(tb_ready), .overflow_o(sat_overflow), .clr_i(clr),
        .drop_cnt_o(sat_drop_cnt), .level_o(sat_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic v, input logic e, input logic i, input logic [4:0] ec,
                           input logic [31:0] a, input logic [31:0] ins, input logic [31:0] tv);
        pkt.valid_ip     = v;
        pkt.exception_ip = e;
        pkt.interrupt_ip = i;
        pkt.ecause_ip    = ec;
        pkt.address_ip   = a;
        pkt.insn_ip      = ins;
        pkt.tval_ip      = tv;
    endtask

    task automatic retire(input logic [31:0] a, input logic [31:0] ins);
        set_pkt(1'b1, 1'b0, 1'b0, 5'd0, a, ins, 32'h0);
        tick();
        pkt = '0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic exp_rec(input logic [31:0] hdr, input logic [31:0] a, input logic [31:0] ins,
                           input logic [31:0] tv, input logic has_tval);
        push_exp(hdr, 1'b0);
        push_exp(a, 1'b0);
        push_exp(ins, !has_tval);
        if (has_tval) push_exp(tv, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || level != 0 || tb_valid) && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    // Monitor: every accepted word must match the queue head; stalled words must hold.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(tb_valid), 32'd1);
                    check("hold_data", tb_data, prev_data);
                    check("hold_last", 32'(tb_last), 32'(prev_last));
                end
                if (tb_valid && tb_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h expected none", tb_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", tb_data, e.data);
                        check("word_last", 32'(tb_last), 32'(e.last));
                    end
                end
                prev_stall = tb_valid && !tb_ready;
                prev_data  = tb_data;
                prev_last  = tb_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        trace_en = 1'b0;
        tb_ready = 1'b0;
        clr      = 1'b0;
        pkt      = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(tb_valid), 32'd0);
        check("rst_data", tb_data, 32'h0);
        check("rst_last", 32'(tb_last), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst      = 1'b0;
        trace_en = 1'b1;
        tb_ready = 1'b1;

        // Single retire
        exp_rec(32'hA002_0000, 32'h0000_1000, 32'h0000_0013, 32'h0, 1'b0);
        retire(32'h0000_1000, 32'h0000_0013);
        wait_drain("drain_single");
        check("single_level", 32'(level), 32'd0);

        // Exception with tval: exception=1, ecause=2, has_tval=1, beats-1=3
        exp_rec(32'hA853_0000, 32'h0000_1004, 32'h0010_0073, 32'hDEAD_BEEF, 1'b1);
        set_pkt(1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_1004, 32'h0010_0073, 32'hDEAD_BEEF);
        tick();
        pkt = '0;
        wait_drain("drain_exc");

        // Overflow: 6 retires into a stalled DEPTH=4 FIFO
        tb_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_rec(32'hA002_0000, 32'h0000_3000 + 32'(4 * k), 32'h0000_0093, 32'h0, 1'b0);
            set_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_3000 + 32'(4 * k), 32'h0000_0093, 32'h0);
            tick();
        end
        pkt = '0;
        @(negedge clk);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        tick();
        tb_ready = 1'b1;
        wait_drain("drain_ovf");
        exp_rec(32'hA00A_0000, 32'h0000_4000, 32'h0000_0113, 32'h0, 1'b0);
        retire(32'h0000_4000, 32'h0000_0113);
        wait_drain("drain_ovf_next");
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_drop", 32'(drop_cnt), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        tick();

        // Backpressure: ready toggles 1,0,1,0 while two records stream
        exp_rec(32'hA002_0000, 32'h0000_2000, 32'h0000_0033, 32'h0, 1'b0);
        exp_rec(32'hA573_0000, 32'h0000_2004, 32'h0000_0073, 32'h0000_0044, 1'b1);
        for (int c = 0; c < 40; c++) begin
            tb_ready = (c % 2 == 0);
            if (c == 0)      set_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_2000, 32'h0000_0033, 32'h0);
            else if (c == 1) set_pkt(1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_2004, 32'h0000_0073, 32'h0000_0044);
            else             pkt = '0;
            tick();
        end
        tb_ready = 1'b1;
        wait_drain("drain_bp");

        // Saturation on the CNT_W=2 instance, then clear coinciding with a drop
        tb_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 4) exp_rec(32'hA002_0000, 32'h0000_5000 + 32'(4 * k), 32'h0000_0193, 32'h0, 1'b0);
            set_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_5000 + 32'(4 * k), 32'h0000_0193, 32'h0);
            tick();
        end
        pkt = '0;
        @(negedge clk);
        check("sat_drop", 32'(sat_drop_cnt), 32'd3);
        check("wide_drop", 32'(drop_cnt), 32'd5);
        check("sat_ovf", 32'(sat_overflow), 32'd1);
        tick();
        clr = 1'b1;
        set_pkt(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_5FFC, 32'h0000_0193, 32'h0);
        tick();
        clr = 1'b0;
        pkt = '0;
        @(negedge clk);
        check("clrdrop_sat_cnt", 32'(sat_drop_cnt), 32'd0);
        check("clrdrop_cnt", 32'(drop_cnt), 32'd0);
        check("clrdrop_ovf", 32'(overflow), 32'd0);
        check("clrdrop_level", 32'(level), 32'd4);
        tick();
        tb_ready = 1'b1;
        wait_drain("drain_sat");
        exp_rec(32'hA00A_0000, 32'h0000_6000, 32'h0000_0213, 32'h0, 1'b0);
        retire(32'h0000_6000, 32'h0000_0213);
        wait_drain("drain_pending");

        // Reset during INSN beat with two records queued
        tb_ready = 1'b0;
        exp_rec(32'hA002_0000, 32'h0000_7000, 32'h0000_7013, 32'h0, 1'b0);
        exp_rec(32'hA002_0000, 32'h0000_7004, 32'h0000_7093, 32'h0, 1'b0);
        retire(32'h0000_7000, 32'h0000_7013);
        retire(32'h0000_7004, 32'h0000_7093);
        tb_ready = 1'b1;
        tick();
        tick();
        tb_ready = 1'b0;
        @(negedge clk);
        check("mid_insn_data", tb_data, 32'h0000_7013);
        check("mid_level", 32'(level), 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_valid", 32'(tb_valid), 32'd0);
        check("rst_mid_level", 32'(level), 32'd0);
        tick();
        tb_ready = 1'b1;
        exp_rec(32'hA002_0000, 32'h0000_8000, 32'h0000_8013, 32'h0, 1'b0);
        retire(32'h0000_8000, 32'h0000_8013);
        wait_drain("drain_after_rst");

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
